dht11_reader: RTL

- Sensor-side driver for the DHT11 single-wire bus on the Arty A7-35. It answers the crossbar's `dht11_start` request and returns the 40-bit frame on `dht11_data`, qualified by `dht11_data_available`.
- Internally it handles the host start pulse, the sensor response handshake, pulse-width decoding of 40 bits, checksum verification, and the mandatory inter-read cooldown.
- The bidirectional pad sits at top level: this block drives only an open-drain enable and reads a raw line input.

---
 rtl/dht11_reader.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/dht11_reader.sv
// dht11_reader: host-side reader for the DHT11 single-wire humidity and temperature sensor.
//
// Sequence of one read:
//   1. Pull the bus low for START_LOW_US.
//   2. Release the bus and follow the sensor's 80/80 us response.
//   3. Decode 40 bits by high-pulse width, MSB first.
//   4. Verify the checksum byte.
//   5. Hold off for COOLDOWN_US before another read can start.
//
// Ports:
//   clk            system clock
//   rst            asynchronous, active-low reset; forces every output to 0
//   start          read request, level-sampled only while idle
//   dht_in         raw bus line (asynchronous, synchronized here)
//   dht_drive_low  open-drain enable: 1 pulls the bus low, 0 releases it
//   data           last frame whose checksum matched
//                    [39:32] RH int, [31:24] RH dec,
//                    [23:16] T int,  [15:8]  T dec,
//                    [7:0]   checksum
//   data_available one-cycle pulse when a good frame is loaded into data
//   error          one-cycle pulse on timeout or checksum mismatch
//   busy           high whenever a read or its cooldown is in progress
module dht11_reader #(
  parameter int CLK_FREQ_HZ   = 100_000_000,
  parameter int START_LOW_US  = 18000,
  parameter int TIMEOUT_US    = 200,
  parameter int BIT_THRESH_US = 48,
  parameter int COOLDOWN_US   = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dht_in,
  output logic        dht_drive_low,
  output logic [39:0] data,
  output logic        data_available,
  output logic        error,
  output logic        busy
);

  localparam int TICK_DIV   = CLK_FREQ_HZ / 1_000_000;
  localparam int PRE_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LONGEST_US = (START_LOW_US > COOLDOWN_US) ? START_LOW_US : COOLDOWN_US;
  localparam int CNT_W      = $clog2(LONGEST_US) + 1;

  typedef enum logic [3:0] {
    IDLE,
    START_LOW,
    WAIT_RESP,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    CHECK,
    COOLDOWN
  } state_t;

  state_t             state_reg, state_next;
  logic [1:0]         sync_reg;
  logic               line_prev_reg;
  logic [PRE_W-1:0]   presc_reg;
  logic [CNT_W-1:0]   us_cnt_reg;
  logic [5:0]         bit_cnt_reg;
  logic [39:0]        shift_reg;
  logic [39:0]        data_reg;
  logic               data_available_reg;
  logic               error_reg;

  logic       line, rise, fall, tick;
  logic       reach_start, reach_timeout, reach_cooldown;
  logic       bit_val, sum_ok;
  logic [7:0] sum_calc;
  logic       shift_en, good_pulse, err_pulse;

  // Edges are taken from the synchronized line only. Waiting on an edge
  // rather than a level matters in WAIT_RESP: the synchronizer still shows
  // our own drive-low for two cycles after release.
  assign line = sync_reg[1];
  assign rise = line & ~line_prev_reg;
  assign fall = ~line & line_prev_reg;
  assign tick = (presc_reg == PRE_W'(TICK_DIV - 1));

  // A limit is reached on the tick that would make the counter equal it.
  // The transition therefore lands exactly N us after state entry.
  assign reach_start    = tick && (us_cnt_reg == CNT_W'(START_LOW_US - 1));
  assign reach_timeout  = tick && (us_cnt_reg == CNT_W'(TIMEOUT_US - 1));
  assign reach_cooldown = tick && (us_cnt_reg == CNT_W'(COOLDOWN_US - 1));

  assign bit_val  = (us_cnt_reg > CNT_W'(BIT_THRESH_US));
  assign sum_calc = shift_reg[39:32] + shift_reg[31:24] + shift_reg[23:16] + shift_reg[15:8];
  assign sum_ok   = (sum_calc == shift_reg[7:0]);

  always_comb begin
    state_next = state_reg;
    shift_en   = 1'b0;
    good_pulse = 1'b0;
    err_pulse  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = START_LOW;
      end
      START_LOW: begin
        if (reach_start) state_next = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (fall) begin
          state_next = RESP_LOW;
        end else if (reach_timeout) begin
          err_pulse  = 1'b1;
          state_next = COOLDOWN;
        end
      end
      RESP_LOW: begin
        if (rise) begin
          state_next = RESP_HIGH;
        end else if (reach_timeout) begin
          err_pulse  = 1'b1;
          state_next = COOLDOWN;
        end
      end
      RESP_HIGH: begin
        if (fall) begin
          state_next = BIT_LOW;
        end else if (reach_timeout) begin
          err_pulse  = 1'b1;
          state_next = COOLDOWN;
        end
      end
      BIT_LOW: begin
        if (rise) begin
          state_next = BIT_HIGH;
        end else if (reach_timeout) begin
          err_pulse  = 1'b1;
          state_next = COOLDOWN;
        end
      end
      BIT_HIGH: begin
        if (fall) begin
          shift_en   = 1'b1;
          state_next = (bit_cnt_reg == 6'd39) ? CHECK : BIT_LOW;
        end else if (reach_timeout) begin
          err_pulse  = 1'b1;
          state_next = COOLDOWN;
        end
      end
      CHECK: begin
        good_pulse = sum_ok;
        err_pulse  = ~sum_ok;
        state_next = COOLDOWN;
      end
      COOLDOWN: begin
        if (reach_cooldown) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg          <= IDLE;
      sync_reg           <= 2'b11;  // idle bus is pulled high
      line_prev_reg      <= 1'b1;
      presc_reg          <= '0;
      us_cnt_reg         <= '0;
      bit_cnt_reg        <= '0;
      shift_reg          <= '0;
      data_reg           <= '0;
      data_available_reg <= 1'b0;
      error_reg          <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sync_reg      <= {sync_reg[0], dht_in};
      line_prev_reg <= line;

      // The prescaler restarts with the state counter, so every timed
      // state lasts a whole number of microseconds from its entry.
      if (state_next != state_reg) begin
        presc_reg  <= '0;
        us_cnt_reg <= '0;
      end else if (tick) begin
        presc_reg  <= '0;
        us_cnt_reg <= us_cnt_reg + 1'b1;
      end else begin
        presc_reg  <= presc_reg + 1'b1;
      end

      // A frame always starts from a zero bit count. Leftovers from an
      // aborted read are cleared while idle.
      if (state_reg == IDLE) begin
        bit_cnt_reg <= '0;
      end else if (shift_en) begin
        bit_cnt_reg <= bit_cnt_reg + 6'd1;
      end

      if (shift_en) shift_reg <= {shift_reg[38:0], bit_val};
      if (good_pulse) data_reg <= shift_reg;
      data_available_reg <= good_pulse;
      error_reg          <= err_pulse;
    end
  end

  assign dht_drive_low  = (state_reg == START_LOW);
  assign busy           = (state_reg != IDLE);
  assign data           = data_reg;
  assign data_available = data_available_reg;
  assign error          = error_reg;

endmodule
